// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite bus bundle between a master and the SRAM slave.
// The master modport drives the address/data phase; the slave returns ready, response and read data.
interface ahbl_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave: 2^ADDR_W x 32 array with configurable wait states,
// byte-lane writes and a two-cycle ERROR response for illegal transfers.
//
// state    | meaning
// ST_IDLE  | ready; completes a pending OKAY data phase, accepts a new address phase
// ST_WAIT  | OKAY data phase stretched by wait states, counter runs down
// ST_ERR1  | first ERROR cycle, hready_out low
// ST_ERR2  | second ERROR cycle, hready_out high, accepts a new address phase
module ahbl_sram_slave #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input logic              cpu_clk,
  input logic              cpu_rst,
  ahbl_sram_slave_if.slave bus
);

  localparam int         TOP       = ADDR_W + 2;
  localparam logic [1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic              dp_valid, dp_write, dp_err;
  logic [TOP-1:0]    dp_addr;
  logic [1:0]        dp_size;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] word;
  logic              ready, in_window, addr_err, acc, ok_dp, commit;
  logic [3:0]        lane_en;
  logic              unused_htrans0;

  assign unused_htrans0 = bus.htrans[0];

  assign ready          = (state == ST_IDLE) || (state == ST_ERR2);
  assign bus.hready_out = ready;
  assign bus.hresp      = {1'b0, (state == ST_ERR1) || (state == ST_ERR2)};

  // BASE_ADDR is window-aligned, so the range check reduces to the upper bits.
  assign in_window = (bus.haddr[31:TOP] == BASE_ADDR[31:TOP]);
  assign addr_err  = (bus.hsize > 3'd2)
                   || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00))
                   || ((bus.hsize == 3'd1) && bus.haddr[0])
                   || !in_window;
  assign acc       = ready && bus.hready_in && bus.hsel && bus.htrans[1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (bus.hready_in) begin
          state_nxt = ST_IDLE;
          if (acc) begin
            if (addr_err) begin
              state_nxt = ST_ERR1;
            end else if (WAIT_CYCLES > 0) begin
              state_nxt = ST_WAIT;
              cnt_nxt   = WAIT_LOAD;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 2'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 2'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state    <= ST_IDLE;
      cnt      <= 2'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_err   <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Data-phase controls only advance when the bus actually moves on.
      if (ready && bus.hready_in) begin
        dp_valid <= acc;
        if (acc) begin
          dp_addr  <= bus.haddr[TOP-1:0];
          dp_size  <= bus.hsize[1:0];
          dp_write <= bus.hwrite;
          dp_err   <= addr_err;
        end
      end
    end
  end

  assign word   = dp_addr[TOP-1:2];
  assign ok_dp  = dp_valid && !dp_err;
  assign commit = ok_dp && dp_write && (state == ST_IDLE) && !cpu_rst;

  always_comb begin
    lane_en = 4'b1111;
    case (dp_size)
      2'd0:    lane_en = 4'b0001 << dp_addr[1:0];
      2'd1:    lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  assign bus.hrdata = (ok_dp && !dp_write && ((state == ST_IDLE) || (state == ST_WAIT)))
                    ? mem[word] : 32'h0;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Bench for ahbl_sram_slave: three instances (1, 0 and 3 wait states) behind one
// master model, with a scoreboard of predicted responses checked at data-phase completion.
module tb_ahbl_sram_slave;

  logic cpu_clk = 1'b0;
  logic cpu_rst;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } op_t;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cur = 0;
  logic        m_hsel, m_hwrite, m_hready_in;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize;
  logic [31:0] m_haddr, m_hwdata;
  logic        rdy_a [3];
  logic [1:0]  resp_a [3];
  logic [31:0] rd_a [3];
  logic        s_ready;
  logic [1:0]  s_resp;
  logic [31:0] s_rdata;
  logic [31:0] model [3][1024];
  exp_t        sb [$];

  ahbl_sram_slave_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    assign bus[g].hsel      = (cur == g) ? m_hsel : 1'b0;
    assign bus[g].haddr     = m_haddr;
    assign bus[g].htrans    = (cur == g) ? m_htrans : 2'd0;
    assign bus[g].hwrite    = m_hwrite;
    assign bus[g].hsize     = m_hsize;
    assign bus[g].hwdata    = m_hwdata;
    assign bus[g].hready_in = (cur == g) ? m_hready_in : 1'b1;
    assign rdy_a[g]  = bus[g].hready_out;
    assign resp_a[g] = bus[g].hresp;
    assign rd_a[g]   = bus[g].hrdata;

    ahbl_sram_slave #(
      .ADDR_W     (10),
      .BASE_ADDR  (32'h2000_0000),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .cpu_clk(cpu_clk),
      .cpu_rst(cpu_rst),
      .bus    (bus[g].slave)
    );
  end

  always_comb begin
    s_ready = (cur == 0) ? rdy_a[0]  : (cur == 1) ? rdy_a[1]  : rdy_a[2];
    s_resp  = (cur == 0) ? resp_a[0] : (cur == 1) ? resp_a[1] : resp_a[2];
    s_rdata = (cur == 0) ? rd_a[0]   : (cur == 1) ? rd_a[1]   : rd_a[2];
  end

  function automatic int wc_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  // Reference behaviour: response, wait count and read data; updates the model memory.
  function automatic exp_t predict(int d, logic sel, logic [1:0] tr, logic wr,
                                   logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    exp_t        e;
    logic        err;
    logic [31:0] mask;
    int          w;
    e.data = 32'h0; e.resp = 2'd0; e.waits = 0;
    if (!(sel && tr[1])) return e;
    err = (sz > 3'd2) || (sz == 3'd2 && a[1:0] != 2'b00) || (sz == 3'd1 && a[0])
        || (a < 32'h2000_0000) || (a > 32'h2000_0FFF);
    if (err) begin
      e.resp = 2'd1; e.waits = 1;
      return e;
    end
    w = int'(a[11:2]);
    e.waits = wc_of(d);
    if (wr) begin
      if (sz == 3'd0)      mask = 32'hFF << (8 * int'(a[1:0]));
      else if (sz == 3'd1) mask = 32'hFFFF << (16 * int'(a[1]));
      else                 mask = 32'hFFFF_FFFF;
      model[d][w] = (model[d][w] & ~mask) | (wd & mask);
    end else begin
      e.data = model[d][w];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic bus_idle();
    m_hsel = 1'b0; m_htrans = 2'd0; m_hwrite = 1'b0; m_hsize = 3'd2;
    m_haddr = 32'h0; m_hready_in = 1'b1;
  endtask

  // Single non-pipelined transfer; records what the slave shows, judges nothing.
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output int waits, output logic [1:0] r0,
                      output logic [1:0] r1, output logic [31:0] dw,
                      output logic [31:0] dl, output bit tmo);
    m_hsel = 1'b1; m_htrans = 2'd2; m_hwrite = wr; m_hsize = sz; m_haddr = a;
    m_hready_in = 1'b1;
    tick();
    bus_idle();
    m_hwdata = wd;
    waits = 0; tmo = 1'b0;
    r0 = s_resp; dw = s_rdata;
    while (s_ready !== 1'b1 && !tmo) begin
      waits++;
      if (waits > 20) tmo = 1'b1;
      tick();
    end
    r1 = s_resp; dl = s_rdata;
    tick();
  endtask

  task automatic test_reset();
    bus_idle();
    m_hwdata = 32'h0;
    cpu_rst = 1'b1;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #1;
      n_chk++;
      if ({s_ready, s_resp, s_rdata} !== {1'b1, 2'd0, 32'h0}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got ready=%b resp=%0d rdata=%h, want 1/0/0",
                 d, s_ready, s_resp, s_rdata);
      end
    end
    cpu_rst = 1'b0;
    cur = 0;
    tick();
  endtask

  task automatic test_single_transfers();
    op_t         ops [$];
    exp_t        e;
    int          waits;
    logic [1:0]  r0, r1;
    logic [31:0] dw, dl;
    bit          tmo;
    cur = 0;
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_0010, 32'hDEAD_BEEF});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_0010, 32'h0});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_0010, 32'h1122_3344});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd0, 32'h2000_0013, 32'h5A00_0000});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_0010, 32'h0});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_0020, 32'h1234_5678});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd1, 32'h2000_0022, 32'hA5A5_0000});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd1, 32'h2000_0023, 32'hFFFF_FFFF});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_0022, 32'hFFFF_FFFF});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd3, 32'h2000_0020, 32'hFFFF_FFFF});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_1000, 32'hFFFF_FFFF});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_1000, 32'h0});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd2, 32'h1FFF_FFFC, 32'h0});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd0, 32'h2000_0021, 32'h0});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd0, 32'h2000_0020, 32'h0000_00EE});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd1, 32'h2000_0020, 32'h0});
    foreach (ops[i]) begin
      sb.push_back(predict(cur, ops[i].sel, ops[i].tr, ops[i].wr, ops[i].sz, ops[i].a, ops[i].wd));
      xfer(ops[i].wr, ops[i].sz, ops[i].a, ops[i].wd, waits, r0, r1, dw, dl, tmo);
      e = sb.pop_front();
      n_chk++;
      if (tmo || waits != e.waits) begin
        n_fail++;
        $display("FAIL single[%0d] waits: got %0d (timeout=%0b) want %0d", i, waits, tmo, e.waits);
      end
      n_chk++;
      if (r0 !== e.resp || r1 !== e.resp) begin
        n_fail++;
        $display("FAIL single[%0d] hresp: got first=%0d last=%0d want %0d", i, r0, r1, e.resp);
      end
      n_chk++;
      if (dw !== e.data || dl !== e.data) begin
        n_fail++;
        $display("FAIL single[%0d] hrdata: got first=%h last=%h want %h", i, dw, dl, e.data);
      end
    end
  endtask

  task automatic test_hready_in_low();
    exp_t        e;
    int          waits;
    logic [1:0]  r0, r1;
    logic [31:0] dw, dl;
    bit          tmo;
    cur = 0;
    m_hsel = 1'b1; m_htrans = 2'd2; m_hwrite = 1'b1; m_hsize = 3'd2;
    m_haddr = 32'h2000_0010; m_hready_in = 1'b0;
    tick();
    bus_idle();
    m_hwdata = 32'hFFFF_FFFF;
    n_chk++;
    if ({s_ready, s_resp} !== {1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL hready_in_low state: got ready=%b resp=%0d want 1/0", s_ready, s_resp);
    end
    tick();
    sb.push_back(predict(cur, 1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_0010, 32'h0));
    xfer(1'b0, 3'd2, 32'h2000_0010, 32'h0, waits, r0, r1, dw, dl, tmo);
    e = sb.pop_front();
    n_chk++;
    if (tmo || dl !== e.data) begin
      n_fail++;
      $display("FAIL hready_in_low readback: got %h want %h", dl, e.data);
    end
  endtask

  task automatic test_back_to_back();
    op_t  ops [$];
    exp_t e;
    int   n;
    cur = 1;
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_0040, 32'hA1B2_C3D4});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_0040, 32'h0});
    ops.push_back('{1'b1, 2'd0, 1'b1, 3'd2, 32'h2000_0040, 32'hFFFF_FFFF});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_0044, 32'h0BAD_F00D});
    ops.push_back('{1'b0, 2'd2, 1'b1, 3'd2, 32'h2000_0044, 32'hFFFF_FFFF});
    ops.push_back('{1'b1, 2'd3, 1'b0, 3'd2, 32'h2000_0044, 32'h0});
    ops.push_back('{1'b1, 2'd1, 1'b0, 3'd2, 32'h2000_0044, 32'h0});
    ops.push_back('{1'b1, 2'd2, 1'b1, 3'd0, 32'h2000_0041, 32'h0000_EE00});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_0040, 32'h0});
    ops.push_back('{1'b0, 2'd0, 1'b0, 3'd2, 32'h2000_0040, 32'h0});
    ops.push_back('{1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_0044, 32'h0});
    n = ops.size();
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        e = sb.pop_front();
        n_chk++;
        if (s_ready !== 1'b1 || s_resp !== e.resp) begin
          n_fail++;
          $display("FAIL b2b[%0d] ready/resp: got %b/%0d want 1/%0d", i - 1, s_ready, s_resp, e.resp);
        end
        n_chk++;
        if (s_rdata !== e.data) begin
          n_fail++;
          $display("FAIL b2b[%0d] hrdata: got %h want %h", i - 1, s_rdata, e.data);
        end
        m_hwdata = ops[i-1].wd;
      end
      if (i < n) begin
        m_hsel = ops[i].sel; m_htrans = ops[i].tr; m_hwrite = ops[i].wr;
        m_hsize = ops[i].sz; m_haddr = ops[i].a; m_hready_in = 1'b1;
        sb.push_back(predict(cur, ops[i].sel, ops[i].tr, ops[i].wr, ops[i].sz, ops[i].a, ops[i].wd));
      end else begin
        bus_idle();
      end
      tick();
    end
  endtask

  task automatic test_reset_abort();
    exp_t        e;
    int          waits;
    logic [1:0]  r0, r1;
    logic [31:0] dw, dl;
    bit          tmo;
    cur = 2;
    sb.push_back(predict(cur, 1'b1, 2'd2, 1'b1, 3'd2, 32'h2000_0080, 32'hCAFE_F00D));
    xfer(1'b1, 3'd2, 32'h2000_0080, 32'hCAFE_F00D, waits, r0, r1, dw, dl, tmo);
    e = sb.pop_front();
    n_chk++;
    if (tmo || waits != e.waits) begin
      n_fail++;
      $display("FAIL abort setup waits: got %0d want %0d", waits, e.waits);
    end
    m_hsel = 1'b1; m_htrans = 2'd2; m_hwrite = 1'b1; m_hsize = 3'd2;
    m_haddr = 32'h2000_0080; m_hready_in = 1'b1;
    tick();
    bus_idle();
    m_hwdata = 32'hFFFF_FFFF;
    n_chk++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort in_wait: got ready=%b want 0", s_ready);
    end
    tick();
    cpu_rst = 1'b1;
    tick();
    n_chk++;
    if ({s_ready, s_resp, s_rdata} !== {1'b1, 2'd0, 32'h0}) begin
      n_fail++;
      $display("FAIL abort after_reset: got ready=%b resp=%0d rdata=%h want 1/0/0",
               s_ready, s_resp, s_rdata);
    end
    cpu_rst = 1'b0;
    tick();
    sb.push_back(predict(cur, 1'b1, 2'd2, 1'b0, 3'd2, 32'h2000_0080, 32'h0));
    xfer(1'b0, 3'd2, 32'h2000_0080, 32'h0, waits, r0, r1, dw, dl, tmo);
    e = sb.pop_front();
    n_chk++;
    if (tmo || waits != e.waits || dl !== e.data) begin
      n_fail++;
      $display("FAIL abort readback: got %h waits=%0d want %h waits=%0d", dl, waits, e.data, e.waits);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpu_rst = 1'b1;
    bus_idle();
    m_hwdata = 32'h0;
    test_reset();
    test_single_transfers();
    test_hready_in_low();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
